// File: rtl/seq_pkg.sv
// Shared types and constants for the pattern step sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int STEPS        = 16;
    localparam int STEP_W       = 4;
    localparam int DIV_HALF_DEF = 250000;   // 100 Hz from a 50 MHz clk

endpackage

// File: rtl/seq_tick_gen.sv
// Prescaler: divides clk down to a 1-cycle tick every 2*DIV_HALF cycles plus a 50% square wave.
// Latency: tick_100hz registered; tick decoded from the prescaler register (no input-to-output path).
// Backpressure: none; free-running, synchronous clear restarts the period from count 0.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   clr             restart the prescaler at 0 on the next edge
//   tick            high in the cycle where the prescaler holds 2*DIV_HALF-1
//   tick_100hz      high while prescaler < DIV_HALF, low otherwise
module seq_tick_gen #(
    parameter int DIV_HALF = 250000,
    parameter int DIV_W    = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic tick_100hz
);

    localparam int            CW   = DIV_W + 1;
    localparam logic [CW-1:0] LAST = CW'(2 * DIV_HALF - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV_HALF);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_hz;

    always_comb begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (clr || (r_cnt == LAST)) begin
            w_cnt_nxt = '0;
        end
    end

    // The square wave is computed from the next count so it stays aligned
    // with the counter value it describes while still being a flop output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_hz  <= 1'b1;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_hz  <= (w_cnt_nxt < HALF);
        end
    end

    assign tick       = (r_cnt == LAST);
    assign tick_100hz = r_hz;

endmodule

// File: rtl/seq_step_controller.sv
// Pattern step sequencer: walks a 16-entry {active,note} pattern at a tempo counted in 100 Hz ticks.
// Latency: play/stop act on the next edge; gate rises one cycle after each step strobe; all outputs registered.
// Backpressure: none; play/stop are single-cycle pulses, stop wins when both are high.
//
// Ports:
//   clk, rst_n                  system clock, synchronous active-low reset
//   play, stop                  start/restart at step 0, halt and drop gate
//   tempo_ticks, gate_ticks     step and gate length in ticks, latched at each step start
//   loop_len                    steps per loop (0 = 16), used at the wrap decision
//   wr_en/wr_addr/wr_note/wr_active   pattern RAM write port
//   note, gate, step_idx        voice outputs and current step
//   step_strobe                 pulse in the first cycle of each step
//   playing                     high in RUN
//   tick_100hz                  100 Hz square wave
module seq_step_controller
    import seq_pkg::*;
#(
    parameter int DIV_HALF = DIV_HALF_DEF,
    parameter int DIV_W    = 19,
    parameter int NOTE_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              stop,
    input  logic [7:0]        tempo_ticks,
    input  logic [7:0]        gate_ticks,
    input  logic [3:0]        loop_len,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic              wr_active,
    output logic [NOTE_W-1:0] note,
    output logic              gate,
    output logic [3:0]        step_idx,
    output logic              step_strobe,
    output logic              playing,
    output logic              tick_100hz
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NOTE_W:0]     r_ram [STEPS];     // {active, note}
    logic [NOTE_W-1:0]   r_note;
    logic                r_active;
    logic                r_gate;
    logic [STEP_W-1:0]   r_step_idx;
    logic                r_strobe;
    logic [7:0]          r_tempo;           // already mapped 0 -> 1
    logic [7:0]          r_gate_len;
    logic [7:0]          r_step_cnt;
    logic [7:0]          r_gate_cnt;

    logic                w_tick;
    logic                w_restart;
    logic                w_halt;
    logic                w_step_end;
    logic                w_gate_end;
    logic                w_step_start;
    logic [STEP_W-1:0]   w_inc;
    logic [STEP_W-1:0]   w_next_idx;

    seq_tick_gen #(
        .DIV_HALF (DIV_HALF),
        .DIV_W    (DIV_W)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_restart),
        .tick       (w_tick),
        .tick_100hz (tick_100hz)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_halt      = 1'b0;
        w_step_end  = 1'b0;
        w_gate_end  = 1'b0;
        case (r_state)
            IDLE: begin
                if (play && !stop) begin
                    w_state_nxt = RUN;
                    w_restart   = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_halt      = 1'b1;
                end else if (play) begin
                    w_restart   = 1'b1;
                end else if (w_tick) begin
                    // The tick that completes the count starts the next step on
                    // this same edge, which keeps strobe-to-strobe at exactly
                    // tempo * 2*DIV_HALF cycles.
                    w_step_end = ({1'b0, r_step_cnt} + 9'd1) == {1'b0, r_tempo};
                    w_gate_end = ({1'b0, r_gate_cnt} + 9'd1) == {1'b0, r_gate_len};
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_step_start = w_restart || w_step_end;
    assign w_inc        = r_step_idx + STEP_W'(1);

    // loop_len of 0 never matches a nonzero increment, so it falls through to
    // the natural 4-bit wrap at 15 -> 0; a shortened loop behind the current
    // step does the same.
    always_comb begin
        w_next_idx = w_inc;
        if (w_restart || (w_inc == loop_len)) begin
            w_next_idx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_note     <= '0;
            r_active   <= 1'b0;
            r_gate     <= 1'b0;
            r_step_idx <= '0;
            r_strobe   <= 1'b0;
            r_tempo    <= 8'd1;
            r_gate_len <= '0;
            r_step_cnt <= '0;
            r_gate_cnt <= '0;
            for (int i = 0; i < STEPS; i++) begin
                r_ram[i] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_strobe <= w_step_start;

            // A write landing on the step being latched this edge is seen only
            // on that step's next start; the read below sees the old word.
            if (wr_en) begin
                r_ram[wr_addr] <= {wr_active, wr_note};
            end

            if (w_halt) begin
                r_gate     <= 1'b0;
                r_step_idx <= '0;
            end else if (w_step_start) begin
                r_step_idx             <= w_next_idx;
                {r_active, r_note}     <= r_ram[w_next_idx];
                r_tempo                <= (tempo_ticks == 8'd0) ? 8'd1 : tempo_ticks;
                r_gate_len             <= gate_ticks;
                r_step_cnt             <= '0;
                r_gate_cnt             <= '0;
                // Low for the strobe cycle: a retrigger edge even when the
                // previous gate ran to the boundary.
                r_gate                 <= 1'b0;
            end else if (r_state == RUN) begin
                if (w_gate_end) begin
                    r_gate <= 1'b0;
                end else if (r_strobe && r_active && (r_gate_len != 8'd0)) begin
                    r_gate <= 1'b1;
                end
                if (w_tick) begin
                    r_step_cnt <= r_step_cnt + 8'd1;
                    r_gate_cnt <= r_gate_cnt + 8'd1;
                end
            end
        end
    end

    assign note        = r_note;
    assign gate        = r_gate;
    assign step_idx    = r_step_idx;
    assign step_strobe = r_strobe;
    assign playing     = (r_state == RUN);

endmodule

// File: tb/tb_seq_step_controller.sv
// Directed bench for seq_step_controller with DIV_HALF=5 (one tick = 10 clk cycles).
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_seq_step_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       play;
    logic       stop;
    logic [7:0] tempo_ticks;
    logic [7:0] gate_ticks;
    logic [3:0] loop_len;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [6:0] wr_note;
    logic       wr_active;
    logic [6:0] note;
    logic       gate;
    logic [3:0] step_idx;
    logic       step_strobe;
    logic       playing;
    logic       tick_100hz;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_step_controller #(
        .DIV_HALF (5),
        .DIV_W    (3),
        .NOTE_W   (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .play        (play),
        .stop        (stop),
        .tempo_ticks (tempo_ticks),
        .gate_ticks  (gate_ticks),
        .loop_len    (loop_len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_note     (wr_note),
        .wr_active   (wr_active),
        .note        (note),
        .gate        (gate),
        .step_idx    (step_idx),
        .step_strobe (step_strobe),
        .playing     (playing),
        .tick_100hz  (tick_100hz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [6:0] n, input logic act);
        wr_en     = 1'b1;
        wr_addr   = a;
        wr_note   = n;
        wr_active = act;
        step();
        wr_en     = 1'b0;
    endtask

    // Steps until the next strobe; counts gate-high samples before it.
    task automatic measure(output int len, output int hi);
        len = 0;
        hi  = 0;
        do begin
            step();
            len++;
            if (!step_strobe && gate) hi++;
        end while (!step_strobe && len < 200);
    endtask

    initial begin
        int len;
        int hi;
        int c;
        logic [6:0] exp_note [4];
        exp_note[0] = 7'd60;
        exp_note[1] = 7'd62;
        exp_note[2] = 7'd64;
        exp_note[3] = 7'd65;

        rst_n       = 1'b0;
        play        = 1'b0;
        stop        = 1'b0;
        tempo_ticks = 8'd0;
        gate_ticks  = 8'd0;
        loop_len    = 4'd0;
        wr_en       = 1'b0;
        wr_addr     = 4'd0;
        wr_note     = 7'd0;
        wr_active   = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_note",   32'(note), 32'd0);
        chk("rst_gate",   32'(gate), 32'd0);
        chk("rst_idx",    32'(step_idx), 32'd0);
        chk("rst_strobe", 32'(step_strobe), 32'd0);
        chk("rst_play",   32'(playing), 32'd0);
        chk("rst_hz",     32'(tick_100hz), 32'd1);
        rst_n = 1'b1;

        // tick_100hz: 5 low, 5 high
        c = 0;
        while (tick_100hz !== 1'b1 && c < 30) begin step(); c++; end
        while (tick_100hz !== 1'b0 && c < 60) begin step(); c++; end
        len = 0;
        while (tick_100hz === 1'b0 && len < 30) begin step(); len++; end
        chk("hz_low", 32'(len), 32'd5);
        len = 0;
        while (tick_100hz === 1'b1 && len < 30) begin step(); len++; end
        chk("hz_high", 32'(len), 32'd5);
        chk("idle_gate", 32'(gate), 32'd0);

        // Load pattern and play
        wr(4'd0, 7'd60, 1'b1);
        wr(4'd1, 7'd62, 1'b1);
        wr(4'd2, 7'd64, 1'b1);
        wr(4'd3, 7'd65, 1'b1);
        tempo_ticks = 8'd2;
        gate_ticks  = 8'd1;
        loop_len    = 4'd4;
        play = 1'b1;
        step();
        play = 1'b0;
        chk("play_strobe", 32'(step_strobe), 32'd1);
        chk("play_idx",    32'(step_idx), 32'd0);
        chk("play_note",   32'(note), 32'd60);
        chk("play_playing", 32'(playing), 32'd1);
        chk("play_gate0",  32'(gate), 32'd0);

        // Steps 0,1,2,3 then back to 0
        for (int k = 0; k < 4; k++) begin
            measure(len, hi);
            chk("seq_len",  32'(len), 32'd20);
            chk("seq_gate", 32'(hi), 32'd9);
            chk("seq_idx",  32'(step_idx), 32'((k + 1) % 4));
            chk("seq_note", 32'(note), 32'(exp_note[(k + 1) % 4]));
        end

        // Rewrite step 1 while it plays
        measure(len, hi);
        chk("w1_idx",  32'(step_idx), 32'd1);
        chk("w1_note", 32'(note), 32'd62);
        wr(4'd1, 7'd70, 1'b1);
        chk("w1_hold", 32'(note), 32'd62);
        measure(len, hi);
        chk("w1_len",  32'(len), 32'd19);
        chk("w1_n2",   32'(note), 32'd64);
        measure(len, hi);
        measure(len, hi);
        chk("w1_n0",   32'(note), 32'd60);
        measure(len, hi);
        chk("w1_new",  32'(note), 32'd70);

        // Step 2 becomes a rest
        wr(4'd2, 7'd64, 1'b0);
        measure(len, hi);
        chk("rest_idx",    32'(step_idx), 32'd2);
        measure(len, hi);
        chk("rest_gate",   32'(hi), 32'd0);
        chk("rest_len",    32'(len), 32'd20);
        chk("rest_strobe", 32'(step_strobe), 32'd1);

        // Gate longer than step: single low cycle at each strobe
        gate_ticks = 8'd4;
        measure(len, hi);
        chk("long_prev", 32'(hi), 32'd9);
        chk("long_s0",   32'(gate), 32'd0);
        measure(len, hi);
        chk("long_hi",   32'(hi), 32'd19);
        chk("long_len",  32'(len), 32'd20);
        chk("long_s1",   32'(gate), 32'd0);
        chk("long_idx",  32'(step_idx), 32'd1);

        // Stop mid-gate
        step();
        step();
        step();
        chk("stop_pre", 32'(gate), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_gate", 32'(gate), 32'd0);
        chk("stop_play", 32'(playing), 32'd0);
        chk("stop_idx",  32'(step_idx), 32'd0);
        chk("stop_note", 32'(note), 32'd70);
        step();
        step();
        chk("stop_nostrobe", 32'(step_strobe), 32'd0);

        // Replay: strobe one cycle after play
        play = 1'b1;
        step();
        play = 1'b0;
        chk("re_strobe", 32'(step_strobe), 32'd1);
        chk("re_idx",    32'(step_idx), 32'd0);
        chk("re_note",   32'(note), 32'd60);
        measure(len, hi);
        chk("re_len",    32'(len), 32'd20);
        chk("re_hi",     32'(hi), 32'd19);

        // play and stop together during RUN
        step();
        play = 1'b1;
        stop = 1'b1;
        step();
        play = 1'b0;
        stop = 1'b0;
        chk("ps_play",   32'(playing), 32'd0);
        chk("ps_gate",   32'(gate), 32'd0);
        chk("ps_strobe", 32'(step_strobe), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_step_controller.md
# seq_step_controller

Pattern step sequencer for the synth. It generates its own 100 Hz step tick by dividing the system clock, which replaces the external counter-plus-comparator pair. It walks a 16-entry pattern of notes and drives `note`/`gate` to the voice. Step length and gate length are counted in 100 Hz ticks, so tempo and articulation are set in 10 ms units.

## Interface
- `DIV_HALF`, default 250000: half-period of the 100 Hz tick, in clk cycles (50 MHz clk). Benches override it small.
- `DIV_W`, default 19: prescaler width; must satisfy 2*DIV_HALF-1 < 2^(DIV_W+1).
- `NOTE_W`, default 7: note number width (MIDI range).
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `play` in 1: pulse; start or restart the pattern at step 0.
- `stop` in 1: pulse; halt the pattern and drop the gate.
- `tempo_ticks` in 8: ticks per step; 0 is treated as 1. Sampled at each step start.
- `gate_ticks` in 8: ticks the gate stays high per step; 0 means the step is a rest. Sampled at each step start.
- `loop_len` in 4: number of steps in the loop; 0 means 16.
- `wr_en` in 1: pattern write strobe.
- `wr_addr` in 4: pattern write address.
- `wr_note` in NOTE_W: note written.
- `wr_active` in 1: step enable written. 0 makes the step a rest.
- `note` out NOTE_W: note of the current step.
- `gate` out 1: voice gate.
- `step_idx` out 4: current step.
- `step_strobe` out 1: one-cycle pulse in the first cycle of every step.
- `playing` out 1: high while in RUN.
- `tick_100hz` out 1: 100 Hz square wave. Low while the prescaler is >= DIV_HALF, high otherwise.

## Operation
- Prescaler counts 0..2*DIV_HALF-1 and then wraps. `tick` is an internal 1-cycle pulse in the cycle where prescaler = 2*DIV_HALF-1.
- Pattern RAM: 16 × {active, note}, written synchronously. It is readable whenever `wr_en` is low or high.
- States:
  - IDLE: `gate`=0, `playing`=0, prescaler free-running.
  - RUN: `playing`=1.
- Transitions:
  - IDLE --`play`--> RUN (step start).
  - RUN --`play`--> RUN (restart at step 0).
  - RUN --`stop`--> IDLE.
  - RUN, step end --> next step start.
- Step start cycle:
  - `step_strobe`=1, `gate`=0.
  - Latch `note` and `active` from RAM[`step_idx`].
  - Latch `tempo_ticks` and `gate_ticks`.
  - Clear the step tick counter and gate tick counter.
- Step start triggered by `play`: `step_idx`=0 and the prescaler is also cleared, so the first step has exact length.
- Cycle after step start: `gate`=1 if active=1 and gate_ticks≠0.
- Each `tick` in RUN increments both tick counters.
  - Gate counter reaching gate_ticks → `gate`=0 the following cycle.
  - Step counter reaching tempo_ticks → next step start the following cycle, with `step_idx` = (`step_idx`+1 == loop_len) ? 0 : `step_idx`+1. A loop_len of 0 compares as 16, i.e. 4-bit wrap.
- If gate_ticks >= tempo_ticks, the gate stays high until the step boundary. It is then low for exactly the strobe cycle, which gives the voice a retrigger edge.
- `stop`: next cycle `gate`=0, `playing`=0, `step_idx`=0. `note` holds its last value.
- Simultaneous `play` and `stop`: `stop` wins.
- `loop_len` is sampled only at the wrap decision. If `step_idx` >= the new length, the sequence advances until the 4-bit wrap at 15→0.
- Write during RUN to the current step: no effect on the latched `note`; it takes effect the next time that step starts.
- Write and read of the same address in the same step-start cycle: the old value is read.
- Reset values: `note`=0, `gate`=0, `step_idx`=0, `step_strobe`=0, `playing`=0, `tick_100hz`=1, prescaler=0, pattern RAM all {0,0}.
- `rst_n` low mid-play: all of the above apply on the next edge; the pattern RAM is cleared.

## Timing
- `play` sampled at edge N.
  - Edge N+1: `step_strobe`, `step_idx`=0, `note` valid, `playing`=1.
  - Edge N+2: `gate` high.
- First tick: 2*DIV_HALF cycles after the step-start edge.
- Step length: exactly tempo_ticks × 2*DIV_HALF cycles, strobe to strobe.
- Gate high time: gate_ticks × 2*DIV_HALF − 1 cycles (when gate_ticks < tempo_ticks).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `seq_pkg`:
  - state enum {IDLE, RUN};
  - `STEPS`=16;
  - `STEP_W`=4;
  - default `DIV_HALF`.
- Sub-module `seq_tick_gen`: prescaler with synchronous clear, outputs `tick` and `tick_100hz`.

## Test plan
- Run every scenario with DIV_HALF=5, so one tick = 10 clk cycles.
- Reset then idle: all outputs at reset values; `tick_100hz` period = 10 cycles, duty 50%.
- Load steps 0..3 = notes 60, 62, 64, 65, all active; tempo=2, gate=1, loop_len=4; pulse `play`:
  - strobes every 20 cycles;
  - `step_idx` sequence 0,1,2,3,0;
  - gate high for 9 cycles per step;
  - `note` values as loaded.
- Step 2 active=0 → no gate during step 2; strobe still occurs.
- gate=4, tempo=2 → gate high except a single low cycle at each strobe.
- `stop` mid-gate:
  - `gate`=0 and `playing`=0 next cycle;
  - a later `play` restarts at step 0, and the first strobe comes 1 cycle after `play`.
- `play`+`stop` in the same cycle during RUN → IDLE.
- Write note 70 to step 1 while step 1 plays → `note` stays 62 until the next loop, then shows 70.
